uib_dma_master: RTL and testbench

- UIB-standard master: copies a block of 32-bit words from a source to a destination address on the UIB bus.
- Sits beside the CPU as a second bus initiator; targets slaves such as main memory.
- Configured through a start/len/src/dst port group driven by a control register block.
- Word-only transfers; one word buffered in flight; fixed-latency read capture.

---
 rtl/uib_dma_master.sv | 165 ++++++++++++++++
 tb/tb_uib_dma_master.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uib_dma_master.sv
// uib_dma_master: UIB bus master copying a block of 32-bit words src -> dst.
// Define UIB_DMA_FILL_EN to add the pattern-fill mode (fill, fill_pat ports).
module uib_dma_master #(
    parameter int XLEN       = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [XLEN-1:0]      src_addr,
    input  logic [XLEN-1:0]      dst_addr,
    input  logic [CNT_WIDTH-1:0] len,
`ifdef UIB_DMA_FILL_EN
    input  logic                 fill,
    input  logic [XLEN-1:0]      fill_pat,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] xfer_cnt,
    output logic                 bus_req,
    output logic                 bus_wen,
    output logic [XLEN-1:0]      bus_addr,
    output logic [1:0]           bus_mode,
    output logic [XLEN-1:0]      bus_dat_o,
    input  logic [XLEN-1:0]      bus_dat_i
);

    localparam int WW = $clog2(RD_LATENCY + 1);
    localparam logic [WW-1:0] LAST = WW'(RD_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

    state_t                state;
    logic [XLEN-1:0]       src;
    logic [XLEN-1:0]       dst;
    logic [XLEN-1:0]       buf_q;
    logic [CNT_WIDTH-1:0]  rem;
    logic [WW-1:0]         wcnt;
    logic                  fill_q;
    logic                  fill_in;
    logic                  bad_align;

`ifdef UIB_DMA_FILL_EN
    assign fill_in = fill;
`else
    assign fill_in = 1'b0;
    assign fill_q  = 1'b0;
`endif

    // fill transfers never read, so only dst alignment matters for them
    assign bad_align = (dst_addr[1:0] != 2'b00) ||
                       (!fill_in && (src_addr[1:0] != 2'b00));

    assign bus_mode  = 2'b10;
    assign bus_dat_o = buf_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            src      <= '0;
            dst      <= '0;
            rem      <= '0;
            buf_q    <= '0;
            wcnt     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            xfer_cnt <= '0;
            bus_req  <= 1'b0;
            bus_wen  <= 1'b0;
            bus_addr <= '0;
`ifdef UIB_DMA_FILL_EN
            fill_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (bad_align) begin
                            err <= 1'b1;
                        end else if (len == '0) begin
                            done     <= 1'b1;
                            xfer_cnt <= '0;
                        end else begin
                            src      <= src_addr;
                            dst      <= dst_addr;
                            rem      <= len;
                            xfer_cnt <= '0;
                            busy     <= 1'b1;
                            bus_req  <= 1'b1;
`ifdef UIB_DMA_FILL_EN
                            fill_q   <= fill;
                            if (fill) begin
                                state    <= WR;
                                bus_wen  <= 1'b1;
                                bus_addr <= dst_addr;
                                buf_q    <= fill_pat;
                            end else begin
                                state    <= RD;
                                bus_addr <= src_addr;
                            end
`else
                            state    <= RD;
                            bus_addr <= src_addr;
`endif
                        end
                    end
                end
                RD: begin
                    bus_req  <= 1'b0;
                    bus_addr <= '0;
                    wcnt     <= '0;
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= CAP;
                    end
                end
                CAP: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (wcnt == LAST) begin
                        buf_q    <= bus_dat_i;
                        bus_req  <= 1'b1;
                        bus_wen  <= 1'b1;
                        bus_addr <= dst;
                        state    <= WR;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                WR: begin
                    src      <= src + XLEN'(4);
                    dst      <= dst + XLEN'(4);
                    xfer_cnt <= xfer_cnt + 1'b1;
                    rem      <= rem - 1'b1;
                    if (abort || rem == CNT_WIDTH'(1)) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= !abort;
                        bus_req  <= 1'b0;
                        bus_wen  <= 1'b0;
                        bus_addr <= '0;
                        buf_q    <= '0;
                    end else if (fill_q) begin
                        bus_addr <= dst + XLEN'(4);
                    end else begin
                        state    <= RD;
                        bus_wen  <= 1'b0;
                        bus_addr <= src + XLEN'(4);
                        buf_q    <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uib_dma_master.sv
// tb_uib_dma_master: randomized scoreboard bench for uib_dma_master.
// Compile with UIB_DMA_FILL_EN defined to also exercise the fill mode.
module tb_uib_dma_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len = '0;
`ifdef UIB_DMA_FILL_EN
    logic        fill = 1'b0;
    logic [31:0] fill_pat = '0;
`endif
    logic        busy, done, err;
    logic [15:0] xfer_cnt;
    logic        bus_req, bus_wen;
    logic [31:0] bus_addr, bus_dat_o;
    logic [1:0]  bus_mode;
    logic [31:0] bus_dat_i = '0;

    uib_dma_master dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
`ifdef UIB_DMA_FILL_EN
        .fill      (fill),
        .fill_pat  (fill_pat),
`endif
        .busy      (busy),
        .done      (done),
        .err       (err),
        .xfer_cnt  (xfer_cnt),
        .bus_req   (bus_req),
        .bus_wen   (bus_wen),
        .bus_addr  (bus_addr),
        .bus_mode  (bus_mode),
        .bus_dat_o (bus_dat_o),
        .bus_dat_i (bus_dat_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mem [logic [31:0]];
    wr_t         exp_wr [$];
    logic [31:0] exp_rd [$];
    logic [1:0]  exp_evt [$];
    logic [15:0] prev_cnt = '0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // read-only slave with one cycle of registered latency
    always @(posedge clk)
        bus_dat_i <= (bus_req && !bus_wen) ? mem_rd(bus_addr) : '0;

    always @(negedge clk) begin
        if (rst) begin
            if (bus_req && bus_wen) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: addr %h data %h, none due",
                             bus_addr, bus_dat_o);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("wr_addr", bus_addr, w.a);
                    chk("wr_data", bus_dat_o, w.d);
                end
            end else if (bus_req) begin
                if (exp_rd.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_read: addr %h, none due", bus_addr);
                end else begin
                    chk("rd_addr", bus_addr, exp_rd.pop_front());
                end
            end else begin
                chk("idle_bus", bus_addr | bus_dat_o, 32'h0);
            end
            if (done || err) begin
                if (exp_evt.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_event: done %b err %b, none due",
                             done, err);
                end else begin
                    chk("event", {30'b0, done, err}, {30'b0, exp_evt.pop_front()});
                end
            end
        end
    end

    // ab: abort cycle (-1 none, -2 together with start); rs: spurious start cycle
    task automatic xfer(input logic [31:0] s, input logic [31:0] d,
                        input int n, input int ab, input int rs,
                        input bit fl, input logic [31:0] pat);
        int   nw, nr, endc, got, per;
        bit   bad, abs, launch;
        logic [15:0] exp_cnt;
        abs    = (ab == -2);
        bad    = (d[1:0] != 2'b00) || (!fl && s[1:0] != 2'b00);
        launch = !abs && !bad && n > 0;
        per    = fl ? 1 : 3;
        nw = 0;
        nr = 0;
        endc = 0;
        exp_cnt = prev_cnt;
        if (launch) begin
            if (ab >= 0 && ab < per * n) begin
                nw   = fl ? ab + 1 : ((ab % 3 == 2) ? ab / 3 + 1 : ab / 3);
                nr   = fl ? 0 : ab / 3 + 1;
                endc = ab + 1;
            end else begin
                nw   = n;
                nr   = fl ? 0 : n;
                endc = per * n;
                exp_evt.push_back(2'b10);
            end
            for (int k = 0; k < nr; k++)
                exp_rd.push_back(s + 32'(4 * k));
            for (int k = 0; k < nw; k++)
                exp_wr.push_back('{a: d + 32'(4 * k),
                                   d: fl ? pat : mem_rd(s + 32'(4 * k))});
            exp_cnt = 16'(nw);
        end else if (!abs && bad) begin
            exp_evt.push_back(2'b01);
        end else if (!abs) begin
            exp_evt.push_back(2'b10);
            exp_cnt = '0;
        end

        @(posedge clk);
        #1;
        start    = 1'b1;
        abort    = abs;
        src_addr = s;
        dst_addr = d;
        len      = 16'(n);
`ifdef UIB_DMA_FILL_EN
        fill     = fl;
        fill_pat = pat;
`endif
        got = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            start = (i == rs);
            abort = (i == ab);
            if (start) begin
                src_addr = $urandom;
                dst_addr = $urandom;
                len      = 16'($urandom_range(1, 5));
            end
            if (!busy) begin
                got = i;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        chk("end_cycle", got, endc);
        chk("xfer_cnt", {16'b0, xfer_cnt}, {16'b0, exp_cnt});
        chk("busy_low", {31'b0, busy}, 32'h0);
        prev_cnt = exp_cnt;
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] s, d;
        int n, ab, rs, mode;
        for (int k = 0; k < 4; k++)
            mem[32'(4 * k)] = 32'(8'h11 * (k + 1));
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {busy, done, err, bus_req, bus_wen, 11'b0, xfer_cnt},
            32'h0);
        chk("rst_bus", bus_addr | bus_dat_o, 32'h0);
        chk("rst_mode", {30'b0, bus_mode}, 32'h2);
        rst = 1'b1;
        @(posedge clk);

        xfer(32'h0, 32'h100, 4, -1, -1, 1'b0, 32'h0);
        xfer(32'h2, 32'h300, 3, -1, -1, 1'b0, 32'h0);
        xfer(32'h40, 32'h500, 0, -1, -1, 1'b0, 32'h0);
        xfer(32'h0, 32'h100, 8, 7, -1, 1'b0, 32'h0);
        xfer(32'h80, 32'hFFFF_FFFC, 2, -1, -1, 1'b0, 32'h0);
        xfer(32'h80, 32'h600, 3, -2, -1, 1'b0, 32'h0);
        xfer(32'h90, 32'h700, 3, -1, 4, 1'b0, 32'h0);
        xfer(32'h90, 32'h701, 2, -1, -1, 1'b0, 32'h0);
`ifdef UIB_DMA_FILL_EN
        xfer(32'h3, 32'h200, 3, -1, -1, 1'b1, 32'hDEAD_BEEF);
`endif

        for (int t = 0; t < 40; t++) begin
            s = $urandom & 32'hFFFF_FFFC;
            d = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) s[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) d[1:0] = 2'($urandom_range(1, 3));
            n    = $urandom_range(0, 6);
            ab   = -1;
            rs   = -1;
            mode = $urandom_range(0, 4);
            if (mode == 0 && n > 0) ab = $urandom_range(0, 3 * n - 1);
            if (mode == 1 && n > 0) rs = $urandom_range(0, 3 * n - 1);
            if (mode == 2) ab = -2;
            xfer(s, d, n, ab, rs, 1'b0, 32'h0);
        end

        repeat (4) @(posedge clk);
        chk("wr_q_drained", exp_wr.size(), 32'h0);
        chk("rd_q_drained", exp_rd.size(), 32'h0);
        chk("evt_q_drained", exp_evt.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
